// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared types, 50 MHz default timing constants and angle-to-width helper for the servo PWM bank
package servo_pkg;

  typedef logic [7:0] angle_t;

  localparam int unsigned FRAME_CYC_50M   = 1000000;
  localparam int unsigned MIN_CYC_544US   = 27200;
  localparam int unsigned CYC_PER_DEG_50M = 515;
  localparam int unsigned SERVO_MAX_ANGLE = 180;

  // Clamped pulse width in clock cycles, computed at 32 bits so no product is truncated.
  function automatic logic [31:0] angle_to_cycles(
    input angle_t      angle,
    input int unsigned min_cyc,
    input int unsigned cyc_per_deg,
    input int unsigned max_angle
  );
    logic [31:0] ang_c;
    ang_c = ({24'd0, angle} > max_angle) ? max_angle : {24'd0, angle};
    return min_cyc + ang_c * cyc_per_deg;
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// rtl/servo_pwm_channel.sv - one servo channel: target/active angle, width register, comparator output
// Optional slew limiting toward the target is enabled by SERVO_BANK_SLEW_EN.
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int unsigned CW           = 20,
  parameter int unsigned MIN_CYC      = MIN_CYC_544US,
  parameter int unsigned CYC_PER_DEG  = CYC_PER_DEG_50M,
  parameter int unsigned MAX_ANGLE    = SERVO_MAX_ANGLE,
  parameter int unsigned RESET_ANGLE  = 90,
  parameter int unsigned MAX_STEP_DEG = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cnt,
  input  logic          wrap,
  input  angle_t        new_target,
  input  logic          new_target_valid,
  output logic          servo,
  output logic          at_target
);

  localparam angle_t        RESET_A = angle_t'((RESET_ANGLE > MAX_ANGLE) ? MAX_ANGLE : RESET_ANGLE);
  localparam logic [CW-1:0] RESET_W = CW'(angle_to_cycles(RESET_A, MIN_CYC, CYC_PER_DEG, MAX_ANGLE));

  if (MAX_STEP_DEG > 255) begin : g_step_err
    $error("servo_pwm_channel: MAX_STEP_DEG does not fit an angle");
  end

  angle_t        target, active, tgt_nxt, act_nxt;
  logic [CW-1:0] width, width_nxt, cnt_nxt;

`ifdef SERVO_BANK_SLEW_EN
  localparam angle_t STEP = angle_t'(MAX_STEP_DEG);
`endif

  always_comb begin
    tgt_nxt = target;
    if (new_target_valid)
      tgt_nxt = ({24'd0, new_target} > MAX_ANGLE) ? angle_t'(MAX_ANGLE) : new_target;
`ifdef SERVO_BANK_SLEW_EN
    act_nxt = active;
    if (tgt_nxt > active)
      act_nxt = ((tgt_nxt - active) > STEP) ? active + STEP : tgt_nxt;
    else if (tgt_nxt < active)
      act_nxt = ((active - tgt_nxt) > STEP) ? active - STEP : tgt_nxt;
`else
    act_nxt = tgt_nxt;
`endif
    // Look one edge ahead so the registered output rises in the cnt==0 cycle.
    width_nxt = wrap ? CW'(angle_to_cycles(act_nxt, MIN_CYC, CYC_PER_DEG, MAX_ANGLE)) : width;
    cnt_nxt   = wrap ? '0 : cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target <= RESET_A;
      active <= RESET_A;
      width  <= RESET_W;
      servo  <= 1'b0;
    end else begin
      servo <= (cnt_nxt < width_nxt);
      if (wrap) begin
        target <= tgt_nxt;
        active <= act_nxt;
        width  <= width_nxt;
      end
    end
  end

  // Both operands are registers that only change on the wrap edge.
  assign at_target = (active == target);

endmodule

// File: rtl/servo_pwm_bank.sv
// rtl/servo_pwm_bank.sv - N-channel servo PWM bank: shared frame counter, pending buffer, load arbitration
// Optional slew limiting per channel is enabled by SERVO_BANK_SLEW_EN.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned FRAME_CYC    = FRAME_CYC_50M,
  parameter int unsigned MIN_CYC      = MIN_CYC_544US,
  parameter int unsigned CYC_PER_DEG  = CYC_PER_DEG_50M,
  parameter int unsigned MAX_ANGLE    = SERVO_MAX_ANGLE,
  parameter int unsigned RESET_ANGLE  = 90,
  parameter int unsigned MAX_STEP_DEG = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [8*N_CH-1:0] angle_in,
  output logic [N_CH-1:0]   servo,
  output logic              frame_tick,
  output logic              pending,
  output logic [N_CH-1:0]   at_target
);

  localparam int unsigned CW = $clog2(FRAME_CYC);

  if (MIN_CYC + MAX_ANGLE * CYC_PER_DEG >= FRAME_CYC) begin : g_cfg_err
    $error("servo_pwm_bank: widest pulse does not fit inside one frame");
  end

  logic [CW-1:0]     cnt;
  logic              wrap;
  logic              nt_valid;
  logic [8*N_CH-1:0] pend_buf;
  logic [8*N_CH-1:0] nt_bus;

  assign wrap     = (cnt == CW'(FRAME_CYC - 1));
  assign nt_valid = wrap && (load || pending);
  // A load on the wrap edge itself is newer than anything buffered.
  assign nt_bus   = load ? angle_in : pend_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= CW'(FRAME_CYC - 1);
      frame_tick <= 1'b0;
      pending    <= 1'b0;
      pend_buf   <= '0;
    end else begin
      cnt        <= wrap ? '0 : cnt + CW'(1);
      frame_tick <= wrap;
      if (wrap) begin
        pending <= 1'b0;
      end else if (load) begin
        pend_buf <= angle_in;
        pending  <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    servo_pwm_channel #(
      .CW           (CW),
      .MIN_CYC      (MIN_CYC),
      .CYC_PER_DEG  (CYC_PER_DEG),
      .MAX_ANGLE    (MAX_ANGLE),
      .RESET_ANGLE  (RESET_ANGLE),
      .MAX_STEP_DEG (MAX_STEP_DEG)
    ) u_ch (
      .clk              (clk),
      .rst              (rst),
      .cnt              (cnt),
      .wrap             (wrap),
      .new_target       (nt_bus[8*i +: 8]),
      .new_target_valid (nt_valid),
      .servo            (servo[i]),
      .at_target        (at_target[i])
    );
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// tb/tb_servo_pwm_bank.sv - directed and table-driven bench for servo_pwm_bank on a 2000-cycle frame
module tb_servo_pwm_bank;

  localparam int FRAME = 2000;
  localparam int MINC  = 100;
  localparam int CPD   = 5;
  localparam int MAXA  = 180;

  typedef struct packed {
    logic [31:0] angles;
    logic [63:0] exp_w;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] angle_in = '0;
  logic [3:0]  servo;
  logic [3:0]  at_target;
  logic        frame_tick;
  logic        pending;

  int checks = 0;
  int errors = 0;
  int hi_cnt[4];
  int meas[4];

  always #5 clk = ~clk;

  servo_pwm_bank #(
    .N_CH(4), .FRAME_CYC(FRAME), .MIN_CYC(MINC), .CYC_PER_DEG(CPD),
    .MAX_ANGLE(MAXA), .RESET_ANGLE(90), .MAX_STEP_DEG(5)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .angle_in(angle_in),
    .servo(servo), .frame_tick(frame_tick), .pending(pending), .at_target(at_target)
  );

  // High-cycle count per channel between consecutive frame ticks.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (frame_tick) begin
        meas[c]   = hi_cnt[c];
        hi_cnt[c] = int'(servo[c]);
      end else begin
        hi_cnt[c] += int'(servo[c]);
      end
    end
  end

  function automatic int model_width(input logic [7:0] a);
    int ac;
    ac = (int'(a) > MAXA) ? MAXA : int'(a);
    return MINC + ac * CPD;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick;
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!frame_tick && g < 3 * FRAME);
    if (!frame_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no frame_tick expected one within %0d cycles", 3 * FRAME);
    end
    #1;
  endtask

  task automatic do_load(input logic [31:0] a);
    angle_in = a;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  initial begin
    vec_t        vecs[3];
    int          prev[4];
    int          cur_w[4];
    logic [31:0] tgt;
    logic [31:0] pbuf;
    logic [31:0] a;
    logic        pend;
    logic        ld;
    int          legal;

    vecs[0] = {{8'd200, 8'd45, 8'd180, 8'd0},   {16'd1000, 16'd325, 16'd1000, 16'd100}};
    vecs[1] = {{8'd255, 8'd30, 8'd20,  8'd10},  {16'd1000, 16'd250, 16'd200,  16'd150}};
    vecs[2] = {{8'd179, 8'd0,  8'd90,  8'd90},  {16'd995,  16'd100, 16'd550,  16'd550}};

    rst = 1'b1;
    step(4);
    chk("rst_servo", servo, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_pending", pending, 0);
    chk("rst_at_target", at_target, 4'hF);
    rst = 1'b0;
    @(negedge clk);
    chk("first_tick", frame_tick, 1);
    chk("first_rise", servo, 4'hF);
    @(negedge clk);
    chk("tick_one_cycle", frame_tick, 0);
    wait_tick;
    for (int c = 0; c < 4; c++) chk($sformatf("reset_width_ch%0d", c), meas[c], 550);

`ifdef SERVO_BANK_SLEW_EN
    step(1000);
    do_load({8'd90, 8'd90, 8'd90, 8'd180});
    for (int k = 1; k <= 18; k++) begin
      wait_tick;
      chk($sformatf("slew_width_f%0d", k), meas[0], 550 + 25 * (k - 1));
      chk($sformatf("slew_at_target_f%0d", k), at_target[0], (k == 18) ? 1 : 0);
    end
    wait_tick;
    chk("slew_final_width", meas[0], 1000);
    chk("slew_other_ch", meas[1], 550);
`else
    for (int c = 0; c < 4; c++) prev[c] = 550;
    for (int v = 0; v < 3; v++) begin
      step(1000);
      do_load(vecs[v].angles);
      chk($sformatf("pending_set_v%0d", v), pending, 1);
      wait_tick;
      chk($sformatf("pending_clear_v%0d", v), pending, 0);
      for (int c = 0; c < 4; c++)
        chk($sformatf("hold_width_v%0d_ch%0d", v, c), meas[c], prev[c]);
      wait_tick;
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("new_width_v%0d_ch%0d", v, c), meas[c], int'(vecs[v].exp_w[16*c +: 16]));
        prev[c] = int'(vecs[v].exp_w[16*c +: 16]);
      end
      chk($sformatf("at_target_v%0d", v), at_target, 4'hF);
    end

    step(500);
    do_load({8'd90, 8'd90, 8'd90, 8'd10});
    step(300);
    do_load({8'd90, 8'd90, 8'd90, 8'd20});
    wait_tick;
    wait_tick;
    chk("last_load_wins", meas[0], 200);
    chk("last_load_ch3", meas[3], 550);

    step(500);
    do_load({8'd90, 8'd90, 8'd90, 8'd60});
    step(1498);
    angle_in = {8'd90, 8'd90, 8'd90, 8'd30};
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    chk("wrap_load_tick", frame_tick, 1);
    chk("wrap_load_pending", pending, 0);
    wait_tick;
    chk("wrap_load_width", meas[0], 250);

    step(300);
    do_load({8'd0, 8'd0, 8'd0, 8'd0});
    chk("pre_rst_pending", pending, 1);
    step(100);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_servo", servo, 0);
    chk("mid_rst_pending", pending, 0);
    step(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_tick", frame_tick, 1);
    wait_tick;
    for (int c = 0; c < 4; c++) chk($sformatf("after_rst_width_ch%0d", c), meas[c], 550);

    // Random loads against a small reference model of the buffer/wrap rules.
    tgt  = {8'd90, 8'd90, 8'd90, 8'd90};
    pend = 1'b0;
    pbuf = '0;
    for (int c = 0; c < 4; c++) cur_w[c] = 550;
    for (int i = 0; i < 8 * FRAME; i++) begin
      ld       = ($urandom_range(0, 39) == 0) || (i == 3 * FRAME - 1);
      a        = $urandom;
      load     = ld;
      angle_in = a;
      @(negedge clk);
      #1;
      if (frame_tick) begin
        for (int c = 0; c < 4; c++) begin
          legal = (meas[c] >= MINC && meas[c] <= MINC + MAXA * CPD && (meas[c] - MINC) % CPD == 0) ? 1 : 0;
          chk($sformatf("rand_legal_ch%0d", c), legal, 1);
          chk($sformatf("rand_width_ch%0d", c), meas[c], cur_w[c]);
        end
        if (ld) tgt = a;
        else if (pend) tgt = pbuf;
        pend = 1'b0;
        chk("rand_pending_wrap", pending, 0);
        for (int c = 0; c < 4; c++) cur_w[c] = model_width(tgt[8*c +: 8]);
      end else if (ld) begin
        pbuf = a;
        pend = 1'b1;
      end
    end
    load = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_bank.md
Name: servo_pwm_bank

Overview:
- Parametrised N-channel hobby-servo PWM generator; successor to the single-channel servo driver.
- One shared frame counter (20 ms at 50 MHz by default) drives N per-channel comparators.
- Angle updates are double-buffered and applied only at frame boundaries, so no output ever sees a truncated or stretched pulse.
- Sits between the motion-control logic, which supplies angles, and the servo output pins.

Parameters:
- N_CH, 4, number of servo channels
- FRAME_CYC, 1000000, clock cycles per PWM frame (20 ms @ 50 MHz)
- MIN_CYC, 27200, pulse width at 0 degrees (544 us)
- CYC_PER_DEG, 515, added cycles per degree (~10.3 us)
- MAX_ANGLE, 180, clamp limit in degrees
- RESET_ANGLE, 90, active angle of every channel after reset
- MAX_STEP_DEG, 5, per-frame slew limit (used only with SERVO_BANK_SLEW_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- load  in  1  strobe: capture angle_in into the pending buffer
- angle_in  in  8*N_CH  angles, channel i at bits [8i+7:8i]
- servo  out  N_CH  PWM outputs
- frame_tick  out  1  high for one cycle when cnt==0
- pending  out  1  a captured update is waiting for the frame boundary
- at_target  out  N_CH  active angle equals target angle

Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- Frame counter
  - cnt has width $clog2(FRAME_CYC) and counts 0..FRAME_CYC-1, then wraps to 0.
  - The wrap edge is the edge on which cnt==FRAME_CYC-1.
- Reset values
  - cnt=FRAME_CYC-1; servo=0; frame_tick=0; pending=0; at_target=all 1s.
  - Active and target angles = RESET_ANGLE.
  - First edge after rst deasserts: cnt=0, frame_tick=1, and the first full pulse starts.
- Output timing
  - servo[i] is registered.
  - servo[i]=1 in exactly those cycles where cnt < width[i], giving exactly width[i] high cycles per frame, rising in the cycle with cnt==0.
  - frame_tick is registered and aligned with cnt==0.
- Width arithmetic
  - Clamp: ang_c = min(angle, MAX_ANGLE).
  - width = MIN_CYC + ang_c*CYC_PER_DEG, computed at full counter width without truncation.
  - Elaboration check: MIN_CYC + MAX_ANGLE*CYC_PER_DEG < FRAME_CYC, otherwise $error.
  - width[i] is updated only on the wrap edge.
- Loading
  - load=1 on any non-wrap edge: angle_in is captured into the pending buffer and pending<=1.
  - Repeated loads before the wrap overwrite the buffer; last one wins.
- Wrap edge
  - If load=1: target <= clamp(angle_in) directly and pending<=0 (newest data wins over the buffer).
  - Else if pending=1: target <= clamp(pending buffer) and pending<=0.
  - Active angle and width[] are then updated from target, as given under Optional Feature.
- Mid-frame load: the current frame's pulses are unaffected.
- Reset mid-frame: immediate return to reset values; any pending update is discarded.
- at_target[i] = (active[i]==target[i]), registered and updated on the wrap edge.

Optional Feature:
- Macro: SERVO_BANK_SLEW_EN.
- Defined:
  - On each wrap edge, active[i] moves toward target[i] by min(|target-active|, MAX_STEP_DEG).
  - width[i] is computed from the new active[i].
  - at_target[i] stays 0 until the angle is reached.
- Undefined:
  - active[i] <= target[i] on the wrap edge.
  - at_target is all 1s one cycle after any wrap.
  - MAX_STEP_DEG is ignored.
- The port list is identical in both builds.

Decomposition:
- Package servo_pkg holds:
  - angle_t (logic [7:0]);
  - default constants FRAME_CYC_50M, MIN_CYC_544US, CYC_PER_DEG_50M, SERVO_MAX_ANGLE;
  - function angle_to_cycles(angle_t) implementing the clamp and width arithmetic.
- Sub-module servo_pwm_channel, instantiated N_CH times via generate. Each instance owns:
  - target/active registers;
  - slew logic;
  - width register;
  - comparator and output register.
- Inputs to servo_pwm_channel: cnt, wrap, new_target, new_target_valid.
- The top level owns the frame counter, pending buffer and load arbitration.

Test Plan:
1. Reset then idle → every servo high exactly 73550 cycles per 1000000-cycle frame, rising when frame_tick=1.
2. load with ch0=0, ch1=180, ch2=45, ch3=200 at cnt=500000 → current frame stays at 73550; next frame widths 27200/119900/50375/119900 (200 clamped); pending 1→0 at the wrap.
3. Two loads in one frame (ch0=10, then ch0=20) → next frame ch0 width 37500; load held on the wrap edge itself with ch0=30 → that new frame already 42650.
4. rst asserted at cnt=300000 with a pending update → servo=0 during reset; after release all widths 73550 and the pending update is discarded.
5. SERVO_BANK_SLEW_EN, ch0 target 90→180 → width grows 2575 cycles per frame for 18 frames; at_target[0]=0 until frame 18, then 1 at width 119900.
6. Short-frame build (FRAME_CYC=2000, MIN_CYC=100, CYC_PER_DEG=5) → angle 180 gives 1000 high cycles; continuous random loads never produce a pulse width other than a value in the legal set.
